// File: rtl/sha3_pkg.sv
// Shared constants and types for the 48-bit SHA-3 slice datapath.
// Used by the state serializer and its matching deserializer.
package sha3_pkg;

    localparam int SLICE48_COUNT = 34;
    localparam int SLICE48_W     = 48;
    localparam int SLICE48_IDX_W = 6;
    localparam int SPARE_W       = 16;

    typedef logic [47:0] slice48_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

endpackage

// File: rtl/sha3_beat_counter.sv
// Beat index counter: clear, saturating increment, terminal flag at LIMIT-1.
// Shared between the serializer and the upstream deserializer.
module sha3_beat_counter
    import sha3_pkg::*;
#(
    parameter int LIMIT = SLICE48_COUNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [SLICE48_IDX_W-1:0] cnt,
    output logic                     term
);

    localparam logic [SLICE48_IDX_W-1:0] LAST = SLICE48_IDX_W'(LIMIT - 1);

    assign term = (cnt == LAST);

    // Holding at LAST keeps the index inside the populated store entries.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !term) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sha3_state_serializer_48.sv
// Captures a 34x48 state vector and streams OUT_BEATS beats with backpressure.
// Optional SHA3_SER48_BEAT_IDX_EN adds the obeat index port and a range check.
module sha3_state_serializer_48
    import sha3_pkg::*;
#(
    parameter int OUT_BEATS = SLICE48_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SLICE48_W-1:0] ivector [SLICE48_COUNT],
    input  logic                 ivalid,
    output logic                 iready,
    output logic [SLICE48_W-1:0] odata,
    output logic                 ovalid,
    input  logic                 oready,
`ifdef SHA3_SER48_BEAT_IDX_EN
    output logic [5:0]           obeat,
`endif
    output logic                 olast
);

    if (OUT_BEATS < 1 || OUT_BEATS > SLICE48_COUNT) begin : g_bad_param
        $error("sha3_state_serializer_48: OUT_BEATS must be 1..34");
    end

    ser_state_t               state_q;
    ser_state_t               state_d;
    logic [SLICE48_W-1:0]     store [SLICE48_COUNT];
    logic [SLICE48_IDX_W-1:0] idx;
    logic                     term;
    logic                     capture;
    logic                     advance;

    assign capture = ivalid && iready;
    assign advance = ovalid && oready && !olast;

    sha3_beat_counter #(
        .LIMIT (OUT_BEATS)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .inc  (advance),
        .cnt  (idx),
        .term (term)
    );

    always_comb begin
        state_d = state_q;
        iready  = 1'b0;
        ovalid  = 1'b0;
        olast   = 1'b0;
        odata   = '0;
        unique case (state_q)
            SER_IDLE: begin
                iready = 1'b1;
                if (ivalid) state_d = SER_SEND;
            end
            SER_SEND: begin
                ovalid = 1'b1;
                olast  = term;
                odata  = store[idx];
                // Last beat taken: accept the next vector in the same cycle.
                if (oready && term) begin
                    iready = 1'b1;
                    if (!ivalid) state_d = SER_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            store <= ivector;
        end
    end

`ifdef SHA3_SER48_BEAT_IDX_EN
    localparam logic [SLICE48_IDX_W-1:0] LAST = SLICE48_IDX_W'(OUT_BEATS - 1);

    assign obeat = ovalid ? idx : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (idx <= LAST);
        end
    end
`endif

endmodule
